// File: rtl/dummy_accelerator_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// dummy_acc_arb_pkg : shared types and helpers for the accelerator arbiter
// Revision: 1.0
// ============================================================================
package dummy_acc_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2
  } arb_state_e;

  localparam int MAX_FIELD_W = 64;
  localparam int MAX_BUS_W   = 2048;

  // Extracts field idx of width w from a zero-extended packed requester bus.
  function automatic logic [MAX_FIELD_W-1:0] slice_field(
    input logic [MAX_BUS_W-1:0] bus,
    input int unsigned          idx,
    input int unsigned          w
  );
    logic [MAX_BUS_W-1:0] shifted;
    shifted = bus >> (idx * w);
    return shifted[MAX_FIELD_W-1:0] & ({MAX_FIELD_W{1'b1}} >> (MAX_FIELD_W - w));
  endfunction

endpackage
`default_nettype wire

// File: rtl/dummy_accelerator_arbiter_if.sv
`default_nettype none
// ============================================================================
// dummy_accelerator_arbiter_if : requester, accelerator and status signals
// Revision: 1.0
// ============================================================================
interface dummy_accelerator_arbiter_if #(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 32,
  parameter int IMM_WIDTH = 11,
  parameter int TAG_WIDTH = 5
);
  localparam int IDX_WIDTH = $clog2(N_REQ);

  logic                       flush_i;
  logic [N_REQ-1:0]           req_valid_i;
  logic [N_REQ-1:0]           req_ready_o;
  logic [N_REQ*WIDTH-1:0]     req_rs1_i;
  logic [N_REQ*IMM_WIDTH-1:0] req_imm_i;
  logic [N_REQ*TAG_WIDTH-1:0] req_tag_i;
  logic [N_REQ-1:0]           rsp_valid_o;
  logic [N_REQ-1:0]           rsp_ready_i;
  logic [WIDTH-1:0]           rsp_result_o;
  logic [TAG_WIDTH-1:0]       rsp_tag_o;
  logic                       acc_flush_o;
  logic                       acc_valid_o;
  logic                       acc_ready_i;
  logic [WIDTH-1:0]           acc_rs1_o;
  logic [IMM_WIDTH-1:0]       acc_imm_o;
  logic [TAG_WIDTH-1:0]       acc_tag_o;
  logic                       acc_valid_i;
  logic                       acc_ready_o;
  logic [WIDTH-1:0]           acc_result_i;
  logic [TAG_WIDTH-1:0]       acc_tag_i;
  logic                       busy_o;
  logic [IDX_WIDTH-1:0]       owner_o;
  logic                       tag_err_o;

  modport slave (
    input  flush_i, req_valid_i, req_rs1_i, req_imm_i, req_tag_i, rsp_ready_i,
           acc_ready_i, acc_valid_i, acc_result_i, acc_tag_i,
    output req_ready_o, rsp_valid_o, rsp_result_o, rsp_tag_o, acc_flush_o,
           acc_valid_o, acc_rs1_o, acc_imm_o, acc_tag_o, acc_ready_o,
           busy_o, owner_o, tag_err_o
  );

  modport master (
    output flush_i, req_valid_i, req_rs1_i, req_imm_i, req_tag_i, rsp_ready_i,
           acc_ready_i, acc_valid_i, acc_result_i, acc_tag_i,
    input  req_ready_o, rsp_valid_o, rsp_result_o, rsp_tag_o, acc_flush_o,
           acc_valid_o, acc_rs1_o, acc_imm_o, acc_tag_o, acc_ready_o,
           busy_o, owner_o, tag_err_o
  );

endinterface
`default_nettype wire

// File: rtl/dummy_acc_rr_pick.sv
`default_nettype none
// ============================================================================
// dummy_acc_rr_pick : combinational round-robin pick starting at ptr
// Revision: 1.0
// ============================================================================
module dummy_acc_rr_pick #(
  parameter int N_REQ     = 4,
  parameter int IDX_WIDTH = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0]     req,
  input  logic [IDX_WIDTH-1:0] ptr,
  output logic [N_REQ-1:0]     gnt,
  output logic [IDX_WIDTH-1:0] idx,
  output logic                 any_valid
);

  always_comb begin
    int cand;
    cand      = 0;
    gnt       = '0;
    idx       = '0;
    any_valid = 1'b0;
    for (int off = 0; off < N_REQ; off++) begin
      // Explicit wrap keeps non-power-of-two requester counts correct.
      cand = int'(ptr) + off;
      if (cand >= N_REQ) begin
        cand = cand - N_REQ;
      end
      if (!any_valid && req[cand]) begin
        any_valid = 1'b1;
        gnt[cand] = 1'b1;
        idx       = IDX_WIDTH'(cand);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dummy_accelerator_arbiter.sv
`default_nettype none
// ============================================================================
// dummy_accelerator_arbiter : round-robin sharing of one accelerator, one op in flight
// Revision: 1.0
// ============================================================================
module dummy_accelerator_arbiter
  import dummy_acc_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 32,
  parameter int IMM_WIDTH = 11,
  parameter int TAG_WIDTH = 5
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  dummy_accelerator_arbiter_if.slave  bus
);

  localparam int IDX_WIDTH = $clog2(N_REQ);

  arb_state_e           state;
  logic [IDX_WIDTH-1:0] rr_ptr;
  logic [IDX_WIDTH-1:0] owner;
  logic [WIDTH-1:0]     rs1_lat;
  logic [IMM_WIDTH-1:0] imm_lat;
  logic [TAG_WIDTH-1:0] tag_lat;
  logic                 tag_err;

  logic [N_REQ-1:0]     win_gnt;
  logic [IDX_WIDTH-1:0] win_idx;
  logic                 any_valid;
  logic [WIDTH-1:0]     win_rs1;
  logic [IMM_WIDTH-1:0] win_imm;
  logic [TAG_WIDTH-1:0] win_tag;
  logic [IDX_WIDTH-1:0] next_ptr;
  logic                 rsp_hs;

  dummy_acc_rr_pick #(
    .N_REQ     (N_REQ),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_pick (
    .req       (bus.req_valid_i),
    .ptr       (rr_ptr),
    .gnt       (win_gnt),
    .idx       (win_idx),
    .any_valid (any_valid)
  );

  assign win_rs1 = WIDTH'(slice_field(MAX_BUS_W'(bus.req_rs1_i), 32'(win_idx), WIDTH));
  assign win_imm = IMM_WIDTH'(slice_field(MAX_BUS_W'(bus.req_imm_i), 32'(win_idx), IMM_WIDTH));
  assign win_tag = TAG_WIDTH'(slice_field(MAX_BUS_W'(bus.req_tag_i), 32'(win_idx), TAG_WIDTH));

  assign next_ptr = (owner == IDX_WIDTH'(N_REQ - 1)) ? '0 : owner + 1'b1;
  assign rsp_hs   = (state == WAIT_RSP) && !bus.flush_i && bus.acc_valid_i
                    && bus.rsp_ready_i[owner];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      owner   <= '0;
      rs1_lat <= '0;
      imm_lat <= '0;
      tag_lat <= '0;
      tag_err <= 1'b0;
    end else if (bus.flush_i) begin
      // Abort keeps fairness pointer and the sticky error intact.
      state   <= IDLE;
      owner   <= '0;
      rs1_lat <= '0;
      imm_lat <= '0;
      tag_lat <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            rs1_lat <= win_rs1;
            imm_lat <= win_imm;
            tag_lat <= win_tag;
            owner   <= win_idx;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.acc_ready_i) begin
            state <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (rsp_hs) begin
            state  <= IDLE;
            rr_ptr <= next_ptr;
            if (bus.acc_tag_i != tag_lat) begin
              tag_err <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.rsp_valid_o = '0;
    if ((state == WAIT_RSP) && !bus.flush_i) begin
      bus.rsp_valid_o[owner] = bus.acc_valid_i;
    end
  end

  assign bus.req_ready_o  = ((state == IDLE) && !bus.flush_i) ? win_gnt : '0;
  assign bus.acc_ready_o  = (state == WAIT_RSP) && !bus.flush_i && bus.rsp_ready_i[owner];
  assign bus.rsp_result_o = bus.acc_result_i;
  assign bus.rsp_tag_o    = bus.acc_tag_i;
  assign bus.acc_flush_o  = bus.flush_i;
  assign bus.acc_valid_o  = (state == ISSUE);
  assign bus.acc_rs1_o    = rs1_lat;
  assign bus.acc_imm_o    = imm_lat;
  assign bus.acc_tag_o    = tag_lat;
  assign bus.busy_o       = (state != IDLE);
  assign bus.owner_o      = owner;
  assign bus.tag_err_o    = tag_err;

endmodule
`default_nettype wire

// File: tb/tb_dummy_accelerator_arbiter.sv
`default_nettype none
// ============================================================================
// tb_dummy_accelerator_arbiter : table-driven and directed checks of the arbiter
// Revision: 1.0
// ============================================================================
module tb_dummy_accelerator_arbiter;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;

  int n_err = 0;
  int n_chk = 0;

  logic [31:0] rs1_a [4];
  logic [10:0] imm_a [4];
  logic [4:0]  tag_a [4];

  typedef struct {
    logic [3:0] v;
    logic [3:0] rdy;
    int         own;
  } vec_t;

  vec_t tbl [13];

  dummy_accelerator_arbiter_if bus ();

  dummy_accelerator_arbiter dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      bus.req_rs1_i[i*32 +: 32] = rs1_a[i];
      bus.req_imm_i[i*11 +: 11] = imm_a[i];
      bus.req_tag_i[i*5 +: 5]   = tag_a[i];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One complete transaction; returned tag is the latched tag XOR tag_flip.
  task automatic op(input logic [3:0] v, input logic [3:0] exp_rdy, input int exp_own,
                    input logic [4:0] tag_flip);
    logic [31:0] exp_res;
    logic [4:0]  ret_tag;
    @(posedge clk); #1;
    bus.req_valid_i = v;
    @(negedge clk);
    chk("req_ready", 64'(bus.req_ready_o), 64'(exp_rdy));
    chk("busy_idle", 64'(bus.busy_o), 64'(1'b0));
    @(posedge clk); #1;
    bus.req_valid_i = '0;
    @(negedge clk);
    chk("acc_valid_issue", 64'(bus.acc_valid_o), 64'(1'b1));
    chk("owner", 64'(bus.owner_o), 64'(exp_own));
    chk("acc_rs1", 64'(bus.acc_rs1_o), 64'(rs1_a[exp_own]));
    chk("acc_imm", 64'(bus.acc_imm_o), 64'(imm_a[exp_own]));
    chk("acc_tag", 64'(bus.acc_tag_o), 64'(tag_a[exp_own]));
    bus.acc_ready_i = 1'b1;
    @(posedge clk); #1;
    exp_res = rs1_a[exp_own] ^ {21'b0, imm_a[exp_own]};
    ret_tag = tag_a[exp_own] ^ tag_flip;
    bus.acc_ready_i  = 1'b0;
    bus.acc_valid_i  = 1'b1;
    bus.acc_result_i = exp_res;
    bus.acc_tag_i    = ret_tag;
    bus.rsp_ready_i  = 4'hF;
    @(negedge clk);
    chk("rsp_valid", 64'(bus.rsp_valid_o), 64'(exp_rdy));
    chk("acc_ready_o", 64'(bus.acc_ready_o), 64'(1'b1));
    chk("rsp_result", 64'(bus.rsp_result_o), 64'(exp_res));
    chk("rsp_tag", 64'(bus.rsp_tag_o), 64'(ret_tag));
    chk("acc_valid_wait", 64'(bus.acc_valid_o), 64'(1'b0));
    @(posedge clk); #1;
    bus.acc_valid_i = 1'b0;
    bus.rsp_ready_i = '0;
    @(negedge clk);
    chk("busy_done", 64'(bus.busy_o), 64'(1'b0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rs1_a = '{32'h0000_1111, 32'h0000_1234, 32'h0000_00F0, 32'hABCD_0000};
    imm_a = '{11'h0A1, 11'h055, 11'h00F, 11'h7FF};
    tag_a = '{5'd1, 5'd2, 5'd3, 5'd4};

    tbl[0]  = '{v: 4'b0100, rdy: 4'b0100, own: 2};
    tbl[1]  = '{v: 4'b1111, rdy: 4'b1000, own: 3};
    tbl[2]  = '{v: 4'b1111, rdy: 4'b0001, own: 0};
    tbl[3]  = '{v: 4'b1111, rdy: 4'b0010, own: 1};
    tbl[4]  = '{v: 4'b1111, rdy: 4'b0100, own: 2};
    tbl[5]  = '{v: 4'b1111, rdy: 4'b1000, own: 3};
    tbl[6]  = '{v: 4'b1111, rdy: 4'b0001, own: 0};
    tbl[7]  = '{v: 4'b1111, rdy: 4'b0010, own: 1};
    tbl[8]  = '{v: 4'b1111, rdy: 4'b0100, own: 2};
    tbl[9]  = '{v: 4'b1111, rdy: 4'b1000, own: 3};
    tbl[10] = '{v: 4'b0011, rdy: 4'b0001, own: 0};
    tbl[11] = '{v: 4'b1001, rdy: 4'b1000, own: 3};
    tbl[12] = '{v: 4'b0110, rdy: 4'b0010, own: 1};

    bus.flush_i      = 1'b0;
    bus.req_valid_i  = 4'b0100;
    bus.rsp_ready_i  = '0;
    bus.acc_ready_i  = 1'b0;
    bus.acc_valid_i  = 1'b0;
    bus.acc_result_i = '0;
    bus.acc_tag_i    = '0;

    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(bus.busy_o), 64'(1'b0));
    chk("rst_acc_valid", 64'(bus.acc_valid_o), 64'(1'b0));
    chk("rst_acc_ready", 64'(bus.acc_ready_o), 64'(1'b0));
    chk("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'(4'b0));
    chk("rst_tag_err", 64'(bus.tag_err_o), 64'(1'b0));
    chk("rst_owner", 64'(bus.owner_o), 64'(0));
    chk("rst_acc_rs1", 64'(bus.acc_rs1_o), 64'(0));
    chk("rst_req_ready", 64'(bus.req_ready_o), 64'(4'b0100));
    bus.req_valid_i = '0;
    #1;
    chk("rst_req_ready_none", 64'(bus.req_ready_o), 64'(4'b0000));
    rst_ni = 1'b1;

    for (int k = 0; k < 13; k++) begin
      op(tbl[k].v, tbl[k].rdy, tbl[k].own, 5'd0);
    end

    // Operand stability: requester 1 changes its operand after acceptance.
    @(posedge clk); #1;
    bus.req_valid_i = 4'b0010;
    @(negedge clk);
    chk("stab_ready", 64'(bus.req_ready_o), 64'(4'b0010));
    @(posedge clk); #1;
    bus.req_valid_i = '0;
    rs1_a[1] = 32'h0000_FFFF;
    @(negedge clk);
    chk("stab_rs1_issue", 64'(bus.acc_rs1_o), 64'(32'h1234));
    bus.acc_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.acc_ready_i = 1'b0;
    @(negedge clk);
    chk("stab_busy", 64'(bus.busy_o), 64'(1'b1));
    chk("stab_rs1_wait", 64'(bus.acc_rs1_o), 64'(32'h1234));
    chk("stab_no_rsp", 64'(bus.rsp_valid_o), 64'(4'b0));
    @(posedge clk); #1;
    bus.acc_valid_i  = 1'b1;
    bus.acc_result_i = 32'h1234 ^ 32'h055;
    bus.acc_tag_i    = 5'd2;
    bus.rsp_ready_i  = 4'hF;
    @(negedge clk);
    chk("stab_rsp_valid", 64'(bus.rsp_valid_o), 64'(4'b0010));
    chk("stab_result", 64'(bus.rsp_result_o), 64'(32'h1261));
    chk("stab_rs1_rsp", 64'(bus.acc_rs1_o), 64'(32'h1234));
    @(posedge clk); #1;
    bus.acc_valid_i = 1'b0;
    bus.rsp_ready_i = '0;
    rs1_a[1] = 32'h0000_1234;

    // Response backpressure on requester 0.
    bus.req_valid_i = 4'b0001;
    @(negedge clk);
    chk("bp_ready", 64'(bus.req_ready_o), 64'(4'b0001));
    @(posedge clk); #1;
    bus.req_valid_i = '0;
    @(negedge clk);
    chk("bp_owner", 64'(bus.owner_o), 64'(0));
    bus.acc_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.acc_ready_i  = 1'b0;
    bus.acc_valid_i  = 1'b1;
    bus.acc_result_i = 32'h0000_11B0;
    bus.acc_tag_i    = 5'd1;
    bus.rsp_ready_i  = '0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_acc_ready", 64'(bus.acc_ready_o), 64'(1'b0));
      chk("bp_busy", 64'(bus.busy_o), 64'(1'b1));
      chk("bp_rsp_valid", 64'(bus.rsp_valid_o), 64'(4'b0001));
      @(posedge clk); #1;
    end
    bus.rsp_ready_i = 4'b0001;
    @(negedge clk);
    chk("bp_release", 64'(bus.acc_ready_o), 64'(1'b1));
    @(posedge clk); #1;
    bus.acc_valid_i = 1'b0;
    bus.rsp_ready_i = '0;
    @(negedge clk);
    chk("bp_idle", 64'(bus.busy_o), 64'(1'b0));

    // Flush while waiting for the response of requester 2.
    @(posedge clk); #1;
    bus.req_valid_i = 4'b0100;
    @(negedge clk);
    chk("fl_ready", 64'(bus.req_ready_o), 64'(4'b0100));
    @(posedge clk); #1;
    bus.req_valid_i = '0;
    @(negedge clk);
    bus.acc_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.acc_ready_i  = 1'b0;
    bus.acc_valid_i  = 1'b1;
    bus.acc_result_i = 32'h0000_00FF;
    bus.acc_tag_i    = 5'd3;
    bus.rsp_ready_i  = 4'hF;
    bus.flush_i      = 1'b1;
    @(negedge clk);
    chk("fl_acc_flush", 64'(bus.acc_flush_o), 64'(1'b1));
    chk("fl_rsp_valid", 64'(bus.rsp_valid_o), 64'(4'b0));
    chk("fl_acc_ready", 64'(bus.acc_ready_o), 64'(1'b0));
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
    @(negedge clk);
    chk("fl_busy", 64'(bus.busy_o), 64'(1'b0));
    chk("fl_no_rsp", 64'(bus.rsp_valid_o), 64'(4'b0));
    chk("fl_cleared", 64'(bus.acc_rs1_o), 64'(0));
    chk("fl_flush_low", 64'(bus.acc_flush_o), 64'(1'b0));
    bus.acc_valid_i = 1'b0;
    bus.rsp_ready_i = '0;
    op(4'b1111, 4'b0010, 1, 5'd0);

    // Asynchronous reset while in ISSUE.
    @(posedge clk); #1;
    bus.req_valid_i = 4'b0100;
    @(posedge clk); #1;
    bus.req_valid_i = '0;
    @(negedge clk);
    chk("ar_issue", 64'(bus.acc_valid_o), 64'(1'b1));
    #2;
    rst_ni = 1'b0;
    #1;
    chk("ar_acc_valid", 64'(bus.acc_valid_o), 64'(1'b0));
    chk("ar_busy", 64'(bus.busy_o), 64'(1'b0));
    chk("ar_owner", 64'(bus.owner_o), 64'(0));
    chk("ar_acc_tag", 64'(bus.acc_tag_o), 64'(0));
    @(negedge clk);
    rst_ni = 1'b1;

    // Tag mismatch: latched tag 6, accelerator returns 7.
    tag_a[0] = 5'd6;
    chk("te_clear", 64'(bus.tag_err_o), 64'(1'b0));
    op(4'b1111, 4'b0001, 0, 5'd1);
    chk("te_set", 64'(bus.tag_err_o), 64'(1'b1));
    op(4'b0010, 4'b0010, 1, 5'd0);
    chk("te_sticky", 64'(bus.tag_err_o), 64'(1'b1));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
